bram_port_arbiter: RTL
======================

Name: bram_port_arbiter

Overview:
- Shares one single-port, byte-writable 32-bit block RAM between two requesters.
- Requester I is the core's instruction fetch and is read-only.
- Requester D is the core's load/store unit and can read or write.
- Both requesters use a valid/ready channel handshake. The block drives the RAM's raw enable, write-enable, address and data pins, and sits between the core bus ports and the BRAM macro.

Parameters:
- ADDR_WIDTH, 15: word-address width; RAM depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: data width. Fixed at 32; the strobe is 4 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_arvalid  in  1  I read request
- i_araddr  in  ADDR_WIDTH  I word address
- i_arready  out  1  I request accepted (1-cycle pulse)
- i_rdata  out  32  I read data
- i_rvalid  out  1  I read data valid
- i_rready  in  1  I accepts read data
- d_arvalid  in  1  D read request
- d_araddr  in  ADDR_WIDTH  D read word address
- d_arready  out  1  D read accepted (pulse)
- d_rdata  out  32  D read data
- d_rvalid  out  1  D read data valid
- d_rready  in  1  D accepts read data
- d_awvalid  in  1  D write address valid
- d_awaddr  in  ADDR_WIDTH  D write word address
- d_wvalid  in  1  D write data valid
- d_wdata  in  32  D write data
- d_wstrb  in  4  D byte strobes; bit n covers bits [8n+7:8n]
- d_awready  out  1  D write address accepted (pulse)
- d_wready  out  1  D write data accepted (pulse, same cycle as d_awready)
- d_bvalid  out  1  D write response valid
- d_bready  in  1  D accepts write response
- mem_en  out  1  RAM access enable
- mem_we  out  4  RAM byte write enables
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, last_grant=D (so I wins the first contention).
- Reset mid-operation: the in-flight transaction is dropped and no response is issued.
- All outputs are registered. At most one transaction is outstanding at any time.
- States: IDLE, ACCESS, RD_RESP, WR_RESP.
- IDLE, candidates:
  - I-rd = i_arvalid.
  - D-wr = d_awvalid & d_wvalid.
  - D-rd = d_arvalid.
  - Within D, a write beats a read.
- IDLE, arbitration between I and D:
  - Round-robin on last_grant.
  - A single requesting side always wins.
  - On grant: latch requester, addr, wdata and wstrb; update last_grant; go to ACCESS.
- ACCESS (1 cycle):
  - mem_en=1, mem_addr=latched addr.
  - Read: mem_we=0, pulse the granted arready, go to RD_RESP.
  - Write: mem_we=wstrb, mem_wdata=wdata, pulse d_awready and d_wready, go to WR_RESP.
- RD_RESP:
  - Capture mem_rdata into the granted rdata; rvalid=1.
  - Hold rdata and rvalid stable until rready=1, then clear rvalid and go to IDLE.
- WR_RESP: d_bvalid=1 until d_bready=1, then clear and go to IDLE.
- Latency:
  - Request to arready: 1 cycle.
  - Request to rvalid: 2 cycles.
  - Request to bvalid: 2 cycles.
  - Minimum back-to-back spacing: 3 cycles per transaction, because IDLE re-arbitrates after the response completes.
- A ready asserted in the same cycle rvalid/bvalid first rises completes the response in that cycle.
- Requesters hold valid and payload until the accept pulse. Dropping valid earlier is a protocol violation; the latched request still executes.
- d_wstrb=0: the access still runs with mem_we=0 and d_bvalid is still returned.
- d_awvalid without d_wvalid (or the reverse) is not a write candidate. If d_arvalid is also high, the D read may be granted instead.
- The I side and the D side are never accepted in the same cycle.

Optional Feature:
- Macro BRAM_ARB_PERF_EN.
- Defined: adds output ports i_grant_cnt[31:0], d_grant_cnt[31:0] and conflict_cnt[31:0].
  - i_grant_cnt and d_grant_cnt increment on each grant to that side.
  - conflict_cnt increments on each IDLE cycle where both sides request.
  - All three clear on rst and wrap modulo 2**32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single I read: preload word 0x0010=0xDEADBEEF, pulse i_arvalid with i_rready=1 -> i_arready at +1, i_rvalid=1 with i_rdata=0xDEADBEEF at +2, one mem_en cycle.
- D byte write: write to 0x0020 with d_wdata=0x11223344, d_wstrb=4'b0101 over an initial 0xAAAAAAAA -> mem_we=4'b0101, d_bvalid at +2; a subsequent D read returns 0xAA22AA44.
- Contention: i_arvalid and d_arvalid held high for 4 transactions after reset -> grant order I, D, I, D; each rvalid returns the correct requester's data.
- Backpressure: D read with d_rready=0 for 5 cycles -> d_rvalid and d_rdata stable throughout; a pending I request is not granted until the cycle after d_rready=1.
- Reset mid-op: assert rst in the ACCESS cycle of a write -> next cycle all outputs 0, no d_bvalid; next request is handled normally and I wins a tie.
- With BRAM_ARB_PERF_EN: the contention test -> i_grant_cnt=2, d_grant_cnt=2, conflict_cnt=4.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port byte-writable BRAM between the read-only I port and the read/write D port.
// Optional grant/conflict counters are compiled in with `define BRAM_ARB_PERF_EN.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_arvalid,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  output logic                    i_arready,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_rvalid,
  input  logic                    i_rready,
  input  logic                    d_arvalid,
  input  logic [ADDR_WIDTH-1:0]   d_araddr,
  output logic                    d_arready,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_rvalid,
  input  logic                    d_rready,
  input  logic                    d_awvalid,
  input  logic [ADDR_WIDTH-1:0]   d_awaddr,
  input  logic                    d_wvalid,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_awready,
  output logic                    d_wready,
  output logic                    d_bvalid,
  input  logic                    d_bready,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef BRAM_ARB_PERF_EN
  ,
  output logic [31:0]             i_grant_cnt,
  output logic [31:0]             d_grant_cnt,
  output logic [31:0]             conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_RESP, WR_RESP} state_t;

  state_t                  state;
  logic                    sel_d;
  logic                    is_wr;
  logic                    last_d;
  logic                    first_beat;
  logic [DATA_WIDTH-1:0]   i_rdata_q;
  logic [DATA_WIDTH-1:0]   d_rdata_q;

  logic d_wr_req;
  logic d_req;
  logic grant_d;

  // On a tie D wins only if I was served last; a lone requester always wins.
  assign d_wr_req = d_awvalid & d_wvalid;
  assign d_req    = d_wr_req | d_arvalid;
  assign grant_d  = d_req & (~i_arvalid | ~last_d);

  // The RAM output register supplies data in the first response cycle; the held copy covers stalls.
  assign i_rdata = (first_beat & ~sel_d) ? mem_rdata : i_rdata_q;
  assign d_rdata = (first_beat &  sel_d) ? mem_rdata : d_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel_d      <= 1'b0;
      is_wr      <= 1'b0;
      last_d     <= 1'b1;
      first_beat <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_arready  <= 1'b0;
      i_rvalid   <= 1'b0;
      d_arready  <= 1'b0;
      d_rvalid   <= 1'b0;
      d_awready  <= 1'b0;
      d_wready   <= 1'b0;
      d_bvalid   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_arvalid | d_req) begin
            state     <= ACCESS;
            sel_d     <= grant_d;
            is_wr     <= grant_d & d_wr_req;
            last_d    <= grant_d;
            mem_en    <= 1'b1;
            i_arready <= ~grant_d;
            d_arready <= grant_d & ~d_wr_req;
            d_awready <= grant_d & d_wr_req;
            d_wready  <= grant_d & d_wr_req;
            if (!grant_d) begin
              mem_addr <= i_araddr;
              mem_we   <= '0;
            end else if (d_wr_req) begin
              mem_addr  <= d_awaddr;
              mem_we    <= d_wstrb;
              mem_wdata <= d_wdata;
            end else begin
              mem_addr <= d_araddr;
              mem_we   <= '0;
            end
          end
        end
        ACCESS: begin
          mem_en    <= 1'b0;
          mem_we    <= '0;
          i_arready <= 1'b0;
          d_arready <= 1'b0;
          d_awready <= 1'b0;
          d_wready  <= 1'b0;
          if (is_wr) begin
            d_bvalid <= 1'b1;
            state    <= WR_RESP;
          end else begin
            if (sel_d) d_rvalid <= 1'b1;
            else       i_rvalid <= 1'b1;
            first_beat <= 1'b1;
            state      <= RD_RESP;
          end
        end
        RD_RESP: begin
          first_beat <= 1'b0;
          if (first_beat) begin
            if (sel_d) d_rdata_q <= mem_rdata;
            else       i_rdata_q <= mem_rdata;
          end
          if (sel_d ? d_rready : i_rready) begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        WR_RESP: begin
          if (d_bready) begin
            d_bvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRAM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      i_grant_cnt  <= '0;
      d_grant_cnt  <= '0;
      conflict_cnt <= '0;
    end else if (state == IDLE) begin
      if (i_arvalid | d_req) begin
        if (grant_d) d_grant_cnt <= d_grant_cnt + 32'd1;
        else         i_grant_cnt <= i_grant_cnt + 32'd1;
      end
      if (i_arvalid & d_req) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule
